// File: rtl/fb_scanout_pkg.sv
// fb_scanout_pkg: default raster timing, CHIP-8 geometry and framebuffer address packing.
// Shared by vga_timing, fb_scanout and the bus interface.
package fb_scanout_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int SCALE_DEF    = 8;
    localparam int X_OFFSET_DEF = 64;
    localparam int Y_OFFSET_DEF = 112;

    localparam int CHIP8_W            = 64;
    localparam int CHIP8_H            = 32;
    localparam int CX_W               = $clog2(CHIP8_W);
    localparam int CY_W               = $clog2(CHIP8_H);
    localparam int FB_ROW_STRIDE_LOG2 = 5;
    localparam int FB_ADDR_W          = CY_W + FB_ROW_STRIDE_LOG2;

    // Row stride is 32 bytes; only bytes 0..7 of each row hold pixels.
    function automatic logic [FB_ADDR_W-1:0] fb_addr_pack(input logic [CY_W-1:0] cy,
                                                          input logic [CX_W-1:0] cx);
        return {cy, {(FB_ROW_STRIDE_LOG2-3){1'b0}}, cx[5:3]};
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: framebuffer read port plus video pins; master = scanout, slave = RAM/display side.
// No handshake: the RAM answers one clock after sampling the address.
interface fb_scanout_if;
    import fb_scanout_pkg::*;

    logic [FB_ADDR_W-1:0] fb_read_address;
    logic [7:0]           fb_ram_out;
    logic                 hsync;
    logic                 vsync;
    logic                 video_active;
    logic                 pixel;
    logic                 vblank_start;

    modport master (
        output fb_read_address, hsync, vsync, video_active, pixel, vblank_start,
        input  fb_ram_out
    );

    modport slave (
        input  fb_read_address, hsync, vsync, video_active, pixel, vblank_start,
        output fb_ram_out
    );

endinterface

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v raster counters with raw sync, active and vblank decode.
// Outputs are decoded from the counter registers with zero added latency; no backpressure.
module vga_timing
    import fb_scanout_pkg::*;
#(
    parameter  int H_ACTIVE = H_ACTIVE_DEF,
    parameter  int H_FP     = H_FP_DEF,
    parameter  int H_SYNC   = H_SYNC_DEF,
    parameter  int H_BP     = H_BP_DEF,
    parameter  int V_ACTIVE = V_ACTIVE_DEF,
    parameter  int V_FP     = V_FP_DEF,
    parameter  int V_SYNC   = V_SYNC_DEF,
    parameter  int V_BP     = V_BP_DEF,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [HW-1:0] h_count_o,
    output logic [VW-1:0] v_count_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          video_active_o,
    output logic          vblank_start_o
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_count_o      = h_q;
    assign v_count_o      = v_q;
    assign hsync_o        = ~((h_q >= HS_START) && (h_q < HS_END));
    assign vsync_o        = ~((v_q >= VS_START) && (v_q < VS_END));
    assign video_active_o = (h_q < H_ACT) && (v_q < V_ACT);
    assign vblank_start_o = (h_q == '0) && (v_q == V_ACT);

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: CHIP-8 64x32 framebuffer to scaled raster; pins lag the counters by 3 clocks, free-running (no backpressure).
// Optional FB_SCANOUT_BORDER_EN draws a 1-pixel frame just outside the image window.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter  int H_ACTIVE = H_ACTIVE_DEF,
    parameter  int H_FP     = H_FP_DEF,
    parameter  int H_SYNC   = H_SYNC_DEF,
    parameter  int H_BP     = H_BP_DEF,
    parameter  int V_ACTIVE = V_ACTIVE_DEF,
    parameter  int V_FP     = V_FP_DEF,
    parameter  int V_SYNC   = V_SYNC_DEF,
    parameter  int V_BP     = V_BP_DEF,
    parameter  int SCALE    = SCALE_DEF,
    parameter  int X_OFFSET = X_OFFSET_DEF,
    parameter  int Y_OFFSET = Y_OFFSET_DEF,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic         clk,
    input  logic         reset_n,
    fb_scanout_if.master bus
);

    localparam int X_END = X_OFFSET + CHIP8_W * SCALE;
    localparam int Y_END = Y_OFFSET + CHIP8_H * SCALE;
    localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] XO      = HW'(X_OFFSET);
    localparam logic [HW-1:0] XE      = HW'(X_END);
    localparam logic [VW-1:0] YO      = VW'(Y_OFFSET);
    localparam logic [VW-1:0] YE      = VW'(Y_END);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [SW-1:0] SC_LAST = SW'(SCALE - 1);

    if (SCALE < 1 || X_END > H_ACTIVE || Y_END > V_ACTIVE) begin : g_bad_geometry
        $error("fb_scanout: scaled image window does not fit inside the active area");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hs_raw, vs_raw, act_raw, vblank_raw;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk           (clk),
        .reset_n       (reset_n),
        .h_count_o     (h_cnt),
        .v_count_o     (v_cnt),
        .hsync_o       (hs_raw),
        .vsync_o       (vs_raw),
        .video_active_o(act_raw),
        .vblank_start_o(vblank_raw)
    );

    logic in_x, in_y, in_win, line_end;
    assign in_x     = (h_cnt >= XO) && (h_cnt < XE);
    assign in_y     = (v_cnt >= YO) && (v_cnt < YE);
    assign in_win   = in_x && in_y;
    assign line_end = (h_cnt == H_LAST);

    // Sub-pixel counters describe the current counter position; they sit at 0
    // outside the window so the first window column/line always starts at 0.
    logic [SW-1:0]   sx_q, sx_d, sy_q, sy_d;
    logic [CX_W-1:0] cx_q, cx_d;
    logic [CY_W-1:0] cy_q, cy_d;

    always_comb begin
        sx_d = '0;
        cx_d = '0;
        if (in_x) begin
            if (sx_q == SC_LAST) begin
                sx_d = '0;
                cx_d = cx_q + 1'b1;
            end else begin
                sx_d = sx_q + 1'b1;
                cx_d = cx_q;
            end
        end
    end

    always_comb begin
        sy_d = sy_q;
        cy_d = cy_q;
        if (line_end) begin
            sy_d = '0;
            cy_d = '0;
            if (in_y) begin
                if (sy_q == SC_LAST) begin
                    cy_d = cy_q + 1'b1;
                end else begin
                    sy_d = sy_q + 1'b1;
                    cy_d = cy_q;
                end
            end
        end
    end

    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    assign addr_d = in_win ? fb_addr_pack(cy_q, cx_q) : '0;

    // Bit index and window flag ride alongside the address so they meet the RAM data.
    logic [2:0] bit1_q, bit2_q;
    logic [1:0] win_q;
    logic [2:0] hs_q, vs_q, act_q;
    logic       pixel_q, pixel_d;

`ifdef FB_SCANOUT_BORDER_EN
    localparam logic [HW-1:0] XB0 = HW'(X_OFFSET - 1);
    localparam logic [VW-1:0] YB0 = VW'(Y_OFFSET - 1);

    if (X_OFFSET < 1 || Y_OFFSET < 1) begin : g_bad_border
        $error("fb_scanout: border needs at least one column and line before the image");
    end

    logic       border_raw;
    logic [1:0] border_q;

    assign border_raw = ((h_cnt == XB0 || h_cnt == XE) && (v_cnt >= YB0) && (v_cnt <= YE))
                     || ((v_cnt == YB0 || v_cnt == YE) && (h_cnt >= XB0) && (h_cnt <= XE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            border_q <= '0;
        end else begin
            border_q <= {border_q[0], border_raw};
        end
    end
`endif

    always_comb begin
        pixel_d = 1'b0;
        if (act_q[1]) begin
            if (win_q[1]) begin
                pixel_d = bus.fb_ram_out[3'd7 - bit2_q];
            end
`ifdef FB_SCANOUT_BORDER_EN
            else begin
                pixel_d = border_q[1];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q    <= '0;
            cx_q    <= '0;
            sy_q    <= '0;
            cy_q    <= '0;
            addr_q  <= '0;
            bit1_q  <= '0;
            bit2_q  <= '0;
            win_q   <= '0;
            hs_q    <= '1;
            vs_q    <= '1;
            act_q   <= '0;
            pixel_q <= 1'b0;
        end else begin
            sx_q    <= sx_d;
            cx_q    <= cx_d;
            sy_q    <= sy_d;
            cy_q    <= cy_d;
            addr_q  <= addr_d;
            bit1_q  <= cx_q[2:0];
            bit2_q  <= bit1_q;
            win_q   <= {win_q[0], in_win};
            hs_q    <= {hs_q[1:0], hs_raw};
            vs_q    <= {vs_q[1:0], vs_raw};
            act_q   <= {act_q[1:0], act_raw};
            pixel_q <= pixel_d;
        end
    end

    assign bus.fb_read_address = addr_q;
    assign bus.hsync           = hs_q[2];
    assign bus.vsync           = vs_q[2];
    assign bus.video_active    = act_q[2];
    assign bus.pixel           = pixel_q;
    assign bus.vblank_start    = vblank_raw;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: a shrunken raster (160x80 total, SCALE 2) exercises image mapping, sync and vblank;
// a default 640x480 instance checks the first-line hsync timing.
module tb_fb_scanout;

    localparam int S_HA = 144, S_HFP = 4, S_HS = 8, S_HBP = 4;
    localparam int S_VA = 72,  S_VFP = 2, S_VS = 2, S_VBP = 4;
    localparam int S_SCALE = 2, S_XO = 8, S_YO = 4;
    localparam int S_HT = 160, S_VT = 80, S_FRAME = 12800;

`ifdef FB_SCANOUT_BORDER_EN
    localparam int BORDER_ONES = 388;
`else
    localparam int BORDER_ONES = 0;
`endif

    logic clk;
    logic reset_n;
    logic [7:0] mem [1024];
    int cyc;
    int n_vec = 0;
    int n_err = 0;

    fb_scanout_if bus_s ();
    fb_scanout_if bus_d ();

    fb_scanout #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .SCALE(S_SCALE), .X_OFFSET(S_XO), .Y_OFFSET(S_YO)
    ) dut_s (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_s.master)
    );

    fb_scanout dut_d (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_d.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) bus_s.fb_ram_out <= mem[bus_s.fb_read_address];
    assign bus_d.fb_ram_out = 8'h00;

    // Edges since reset release; at a negedge cyc == n means the DUT has seen n edges.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    int one_tl, one_br, one_other, one_inact;
    int hs_bad, vs_bad, act_bad, max_addr, addr_bad, vs_low;
    int vb_cnt, vb1, vb2;
    int s_f1, s_r1, s_f2, d_f1, d_r1, d_f2;

    // Pins describe raster position cyc-3 of the small instance.
    task automatic scan(input int last);
        int p, h, v;
        logic hs_e, vs_e, act_e, prev_s, prev_d;
        one_tl = 0; one_br = 0; one_other = 0; one_inact = 0;
        hs_bad = 0; vs_bad = 0; act_bad = 0; max_addr = 0; addr_bad = 0; vs_low = 0;
        vb_cnt = 0; vb1 = -1; vb2 = -1;
        s_f1 = -1; s_r1 = -1; s_f2 = -1; d_f1 = -1; d_r1 = -1; d_f2 = -1;
        prev_s = 1'b1;
        prev_d = 1'b1;
        while (cyc < last) begin
            @(negedge clk);
            p = cyc - 3;
            if (p < 0) begin
                h = -1; v = -1; hs_e = 1'b1; vs_e = 1'b1; act_e = 1'b0;
            end else begin
                h = p % S_HT;
                v = (p / S_HT) % S_VT;
                hs_e  = !(h >= 148 && h < 156);
                vs_e  = !(v >= 74 && v < 76);
                act_e = (h < 144) && (v < 72);
            end
            if (bus_s.hsync !== hs_e) hs_bad++;
            if (bus_s.vsync !== vs_e) vs_bad++;
            if (bus_s.video_active !== act_e) act_bad++;
            if (bus_s.pixel === 1'b1) begin
                if (bus_s.video_active !== 1'b1) one_inact++;
                if (h >= 8 && h <= 9 && v >= 4 && v <= 5) one_tl++;
                else if (h >= 134 && h <= 135 && v >= 66 && v <= 67) one_br++;
                else one_other++;
            end else if (bus_s.pixel !== 1'b0) begin
                one_other++;
            end
            if (int'(bus_s.fb_read_address) > max_addr) max_addr = int'(bus_s.fb_read_address);
            if (bus_s.fb_read_address[4:3] !== 2'b00) addr_bad++;
            if (cyc <= S_FRAME && bus_s.vsync === 1'b0) vs_low++;
            if (bus_s.vblank_start !== 1'b0) begin
                vb_cnt++;
                if (vb_cnt == 1) vb1 = cyc;
                else if (vb_cnt == 2) vb2 = cyc;
            end
            if (prev_s === 1'b1 && bus_s.hsync === 1'b0) begin
                if (s_f1 < 0) s_f1 = cyc;
                else if (s_f2 < 0) s_f2 = cyc;
            end
            if (prev_s === 1'b0 && bus_s.hsync === 1'b1 && s_r1 < 0) s_r1 = cyc;
            if (prev_d === 1'b1 && bus_d.hsync === 1'b0) begin
                if (d_f1 < 0) d_f1 = cyc;
                else if (d_f2 < 0) d_f2 = cyc;
            end
            if (prev_d === 1'b0 && bus_d.hsync === 1'b1 && d_r1 < 0) d_r1 = cyc;
            prev_s = bus_s.hsync;
            prev_d = bus_d.hsync;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0]   = 8'h80;
        mem[999] = 8'h01;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_s_hsync", bus_s.hsync, 1);
        chk("rst_s_vsync", bus_s.vsync, 1);
        chk("rst_s_active", bus_s.video_active, 0);
        chk("rst_s_pixel", bus_s.pixel, 0);
        chk("rst_s_addr", bus_s.fb_read_address, 0);
        chk("rst_s_vblank", bus_s.vblank_start, 0);
        chk("rst_d_hsync", bus_d.hsync, 1);
        chk("rst_d_active", bus_d.video_active, 0);

        #2 reset_n = 1'b1;
        scan(2 * S_FRAME);
        chk("s_hs_fall", s_f1, 151);
        chk("s_hs_low", s_r1 - s_f1, 8);
        chk("s_line", s_f2 - s_f1, 160);
        chk("d_hs_fall", d_f1, 659);
        chk("d_hs_low", d_r1 - d_f1, 96);
        chk("d_line", d_f2 - d_f1, 800);
        chk("vs_low", vs_low, 320);
        chk("vb_count", vb_cnt, 2);
        chk("vb_first", vb1, 11520);
        chk("vb_period", vb2 - vb1, 12800);
        chk("hs_seq", hs_bad, 0);
        chk("vs_seq", vs_bad, 0);
        chk("act_seq", act_bad, 0);
        chk("px_topleft", one_tl, 8);
        chk("px_botright", one_br, 8);
        chk("px_other", one_other, 2 * BORDER_ONES);
        chk("px_inactive", one_inact, 0);
        chk("addr_max", max_addr, 999);
        chk("addr_pad", addr_bad, 0);

        // Address of counter (72,40): cy 18, cx 32 -> 18*32 + 4.
        repeat (2 * S_FRAME + 40 * S_HT + 72 + 1 - cyc) @(negedge clk);
        chk("mid_addr", bus_s.fb_read_address, 580);
        chk("mid_active", bus_s.video_active, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr1_addr", bus_s.fb_read_address, 0);
        chk("mr1_active", bus_s.video_active, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        repeat (66 * S_HT + 135 + 3 - cyc) @(negedge clk);
        chk("mid_pixel", bus_s.pixel, 1);
        chk("mid_active2", bus_s.video_active, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr2_pixel", bus_s.pixel, 0);
        chk("mr2_active", bus_s.video_active, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        scan(S_FRAME);
        chk("f2_hs_fall", s_f1, 151);
        chk("f2_vb_count", vb_cnt, 1);
        chk("f2_vb_first", vb1, 11520);
        chk("f2_vs_low", vs_low, 320);
        chk("f2_hs_seq", hs_bad, 0);
        chk("f2_act_seq", act_bad, 0);
        chk("f2_topleft", one_tl, 4);
        chk("f2_botright", one_br, 4);
        chk("f2_other", one_other, BORDER_ONES);

        repeat (S_FRAME + 74 * S_HT + 150 + 3 - cyc) @(negedge clk);
        chk("mid_hsync", bus_s.hsync, 0);
        chk("mid_vsync", bus_s.vsync, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mr3_hsync", bus_s.hsync, 1);
        chk("mr3_vsync", bus_s.vsync, 1);
        chk("mr3_vblank", bus_s.vblank_start, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

- Reads the 64x32 1bpp CHIP-8 framebuffer RAM that the renderer fills, and drives a VGA-style raster (640x480 by default) to the display pins.
- Each CHIP-8 pixel is magnified SCALE times in both axes and the image is placed at a fixed offset.
- Produces a per-frame vblank pulse so the renderer's copy lands outside active video.
- Sits between the framebuffer RAM read port and the video output pins, clocked by the pixel clock.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal front porch, sync, back porch
- V_ACTIVE, 480: visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical front porch, sync, back porch
- SCALE, 8: magnification per CHIP-8 pixel, ≥1
- X_OFFSET, 64: first visible column of the image
- Y_OFFSET, 112: first visible line of the image
- clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- fb_read_address  out  10  framebuffer RAM read address
- fb_ram_out  in  8  RAM read data, registered RAM (valid 1 clock after address is sampled)
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_active  out  1  high while the output pixel is in the visible area
- pixel  out  1  monochrome pixel value
- vblank_start  out  1  one-cycle pulse at start of vertical blanking

## Operation
- Counters:
  - h_count runs 0..H_TOTAL-1; H_TOTAL = sum of the H parameters (800).
  - v_count runs 0..V_TOTAL-1 (525); it increments when h_count wraps.
  - Both counters wrap to 0 together at end of frame.
- Sync:
  - hsync is low for h in [H_ACTIVE+H_FP, +H_SYNC), i.e. [656,752).
  - vsync is low for v in [490,492).
  - video_active = h<H_ACTIVE && v<V_ACTIVE.
- Image window: x in [X_OFFSET, X_OFFSET+64*SCALE), y in [Y_OFFSET, Y_OFFSET+32*SCALE).
- Coordinate tracking:
  - Sub-pixel counters step cx 0..63 and cy 0..31 every SCALE columns/lines.
  - No divider is used.
- Address: fb_read_address = {cy[4:0], 2'b00, cx[5:3]}. Row stride is 32 bytes, of which bytes 0..7 are used.
- Outside the window fb_read_address is 0.
- Bit select: pixel = byte[7 - cx[2:0]], MSB leftmost.
- pixel is 0 outside the window and whenever video_active is 0.
- vblank_start pulses at h==0, v==V_ACTIVE, at counter stage (not delayed). Exactly one pulse per frame.
- Bounds: X_OFFSET+64*SCALE ≤ H_ACTIVE and Y_OFFSET+32*SCALE ≤ V_ACTIVE are mandatory. Elaboration fails otherwise.

## Timing
- Pipeline, from counter position at edge E0:
  - fb_read_address is registered at E1.
  - The RAM samples the address at E2.
  - pixel is registered from fb_ram_out at E3.
- The bit index passes through a matching delay.
- hsync, vsync and video_active pass through a 3-stage delay line. All pin outputs describe the same raster position, 3 cycles after the counters.
- Reset values, applied asynchronously:
  - Counters and sub-pixel counters: 0.
  - Delay lines: inactive.
  - hsync=1, vsync=1, video_active=0, pixel=0, fb_read_address=0, vblank_start=0.
- After reset release the counters start at (0,0) on the first edge. The first hsync falling edge reaches the pin 659 cycles after release.
- Reset mid-frame: outputs go to reset values immediately. No partial line is resumed.
- RAM contents may change at any time. No handshake is required. Tearing during active video is the renderer's responsibility (it starts on vblank_start).

## Configuration
- FB_SCANOUT_BORDER_EN, defined:
  - pixel=1 on a 1-pixel frame just outside the image window.
  - Frame columns: X_OFFSET-1 and X_OFFSET+64*SCALE, over lines Y_OFFSET-1..Y_OFFSET+32*SCALE.
  - Frame lines: Y_OFFSET-1 and Y_OFFSET+32*SCALE, over the same column range.
  - Requires X_OFFSET≥1 and Y_OFFSET≥1.
- Undefined: no border logic; pixel is always 0 outside the window.

## Structure
- fb_scanout_pkg holds:
  - default timing constants.
  - CHIP8_W=64, CHIP8_H=32.
  - FB_ROW_STRIDE_LOG2=5.
  - the address-pack function.
- Sub-module vga_timing contains the h/v counters and produces raw hsync, vsync, video_active and vblank_start.
- fb_scanout contains window/sub-pixel tracking, the address register, bit select, delay lines and border.

## Test plan
- Sync timing: from reset release, hsync falls at cycle 659 and is low for 96 cycles. Line period is 800 cycles; frame is 420000 cycles. vsync is low for exactly 1600 cycles.
- Top-left byte: RAM model with addr 0 = 0x80, all else 0 → pixel=1 only at x 64..71, y 112..119, aligned with video_active.
- Bottom-right mapping: addr 0x3E7 = 0x01 → pixel=1 only at x 568..575, y 360..367. fb_read_address never exceeds 0x3E7 and uses only {row,00,byte}.
- vblank_start: exactly one single-cycle pulse per frame, consecutive pulses 420000 cycles apart, coincident with counter (480,0).
- Mid-frame reset: drop reset_n at line 200 → outputs at reset values with no clock edge. After release, a full correct frame follows from (0,0).
- Border: FB_SCANOUT_BORDER_EN defined, RAM all zero → pixel=1 exactly on x=63/576 (y 111..368) and y=111/368 (x 63..576). Undefined → pixel always 0.
